// File: rtl/bus_pkg.sv
// Shared definitions for the datapath bus arbiter: source indices, arbiter
// states and a one-hot helper.
package bus_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned SRC_W   = 2;

  localparam logic [SRC_W-1:0] SRC_ALU = 2'd0;
  localparam logic [SRC_W-1:0] SRC_MEM = 2'd1;
  localparam logic [SRC_W-1:0] SRC_REG = 2'd2;
  localparam logic [SRC_W-1:0] SRC_CTL = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StTurn
  } arb_state_e;

  function automatic logic [NUM_SRC-1:0] src_onehot(input logic [SRC_W-1:0] idx);
    logic [NUM_SRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: searches from last+1 upward with wrap,
// optionally skipping one index (the current owner during preemption).
module rr_pick
  import bus_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   last,
  input  logic               exclude_en,
  input  logic [SRC_W-1:0]   exclude_idx,
  output logic               found,
  output logic [SRC_W-1:0]   winner
);

  logic [NUM_SRC-1:0] cand;

  assign cand = exclude_en ? (req & ~src_onehot(exclude_idx)) : req;

  // k = NUM_SRC wraps back to last itself, giving it lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      if (!found && cand[last + SRC_W'(k)]) begin
        found  = 1'b1;
        winner = last + SRC_W'(k);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared 16-bit datapath bus with registered one-hot
// drive enables. Define BUS_ARB_TURNAROUND_EN to insert one dead cycle per hand-off.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  output logic               alu_out_en,
  output logic               mem_out_en,
  output logic               reg_out_en,
  output logic               ctl_out_en,
  output logic [SRC_W-1:0]   bus_sel,
  output logic               busy,
  output logic               preempt
);

  // Last hold count before a forced hand-off; with MAX_HOLD = 0 it only marks saturation.
  localparam logic [HOLD_W-1:0] HoldLast = (MAX_HOLD == 0) ? {HOLD_W{1'b1}}
                                                           : HOLD_W'(MAX_HOLD - 1);

  arb_state_e         state_q, state_d;
  logic [SRC_W-1:0]   sel_q, sel_d;
  logic [SRC_W-1:0]   last_q, last_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               preempt_q, preempt_d;

  logic               pick_found;
  logic [SRC_W-1:0]   pick_winner;
  logic               owner_held;
  logic               others_pending;

  assign owner_held     = req[sel_q];
  assign others_pending = |(req & ~src_onehot(sel_q));

  rr_pick u_rr_pick (
    .req         (req),
    .last        (last_q),
    .exclude_en  (state_q == StGrant),
    .exclude_idx (sel_q),
    .found       (pick_found),
    .winner      (pick_winner)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StGrant;
          sel_d   = pick_winner;
          last_d  = pick_winner;
          hold_d  = '0;
        end
      end

      StGrant: begin
        if (!owner_held || ((MAX_HOLD != 0) && (hold_q == HoldLast) && others_pending)) begin
          preempt_d = owner_held;
          hold_d    = '0;
          if (pick_found) begin
`ifdef BUS_ARB_TURNAROUND_EN
            state_d = StTurn;
            sel_d   = '0;
`else
            state_d = StGrant;
            sel_d   = pick_winner;
            last_d  = pick_winner;
`endif
          end else begin
            state_d = StIdle;
            sel_d   = '0;
          end
        end else if (hold_q != HoldLast) begin
          hold_d = hold_q + 1'b1;
        end
      end

      StTurn: begin
        hold_d = '0;
        if (pick_found) begin
          state_d = StGrant;
          sel_d   = pick_winner;
          last_d  = pick_winner;
        end else begin
          state_d = StIdle;
          sel_d   = '0;
        end
      end

      default: begin
        state_d = StIdle;
        sel_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  // Enables are derived from the next state so they register in the same edge as it.
  always_comb begin
    busy_d  = (state_d == StGrant);
    grant_d = busy_d ? src_onehot(sel_d) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      last_q    <= SRC_CTL;
      hold_q    <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
    end
  end

  assign alu_out_en = grant_q[SRC_ALU];
  assign mem_out_en = grant_q[SRC_MEM];
  assign reg_out_en = grant_q[SRC_REG];
  assign ctl_out_en = grant_q[SRC_CTL];
  assign bus_sel    = sel_q;
  assign busy       = busy_q;
  assign preempt    = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (MAX_HOLD = 8); expectations
// follow BUS_ARB_TURNAROUND_EN when it is defined.
module tb_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       alu_out_en, mem_out_en, reg_out_en, ctl_out_en;
  logic [1:0] bus_sel;
  logic       busy;
  logic       preempt;
  logic [3:0] en;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  bus_arbiter #(
    .MAX_HOLD (8),
    .HOLD_W   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .alu_out_en (alu_out_en),
    .mem_out_en (mem_out_en),
    .reg_out_en (reg_out_en),
    .ctl_out_en (ctl_out_en),
    .bus_sel    (bus_sel),
    .busy       (busy),
    .preempt    (preempt)
  );

  assign en = {ctl_out_en, reg_out_en, mem_out_en, alu_out_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ownership change: with turnaround there is one dead cycle first.
  task automatic handoff_step(input string tag);
    step();
`ifdef BUS_ARB_TURNAROUND_EN
    check_eq({tag, "_turn"}, 32'({busy, en}), 32'h0);
    step();
`endif
  endtask

  task automatic check_owner(input string tag, input logic [3:0] exp_en, input logic [1:0] exp_sel);
    check_eq({tag, "_en"}, 32'(en), 32'(exp_en));
    check_eq({tag, "_sel"}, 32'(bus_sel), 32'(exp_sel));
    check_eq({tag, "_busy"}, 32'(busy), 32'(exp_en != 4'b0));
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    int unsigned period;
    int unsigned seg;
    int unsigned pos;
    logic [3:0]  exp_en;
    logic        exp_pre;

    rst = 1'b0;
    req = 4'b0000;
    #12;
    check_owner("reset", 4'b0000, 2'd0);
    check_eq("reset_preempt", 32'(preempt), 32'h0);

    // MEM beats REG from a fresh search starting at ALU.
    step();
    rst = 1'b1;
    req = 4'b0110;
    step();
    check_owner("first_grant_mem", 4'b0010, 2'd1);
    step();
    step();
    check_owner("mem_hold", 4'b0010, 2'd1);
    req = 4'b0100;
    handoff_step("mem_to_reg");
    check_owner("mem_to_reg", 4'b0100, 2'd2);
    req = 4'b0000;
    step();
    check_owner("reg_release_idle", 4'b0000, 2'd0);

    // All four requesting: rotation with forced hand-off every 8 cycles.
    pulse_reset();
    req = 4'b1111;
`ifdef BUS_ARB_TURNAROUND_EN
    period = 9;
`else
    period = 8;
`endif
    for (int unsigned i = 0; i < 40; i++) begin
      step();
      seg = i / period;
      pos = i % period;
      if (pos == 8) begin
        exp_en  = 4'b0000;
        exp_pre = 1'b1;
      end else begin
        exp_en  = 4'b0001 << (seg % 4);
        exp_pre = (period == 8) && (pos == 0) && (i > 0);
      end
      check_eq($sformatf("rot%0d_en", i), 32'(en), 32'(exp_en));
      check_eq($sformatf("rot%0d_pre", i), 32'(preempt), 32'(exp_pre));
      check_eq($sformatf("rot%0d_onehot", i), 32'($countones(en) <= 1), 32'h1);
    end

    // Lone ALU keeps the bus; its saturated hold count forces an immediate hand-off later.
    req = 4'b0000;
    step();
    check_owner("rot_release_idle", 4'b0000, 2'd0);
    req = 4'b0001;
    step();
    check_owner("alu_alone_grant", 4'b0001, 2'd0);
    for (int unsigned i = 0; i < 20; i++) begin
      step();
      check_eq($sformatf("alu_alone%0d", i), 32'({preempt, en}), 32'h01);
    end
    req = 4'b0011;
    step();
    check_eq("alu_sat_preempt", 32'(preempt), 32'h1);
`ifdef BUS_ARB_TURNAROUND_EN
    check_owner("alu_sat_turn", 4'b0000, 2'd0);
    step();
`endif
    check_owner("alu_sat_to_mem", 4'b0010, 2'd1);

    // MEM drops as CTL rises; MEM re-requests and must wait for CTL.
    req = 4'b0000;
    step();
    check_owner("idle_again", 4'b0000, 2'd0);
    req = 4'b0010;
    step();
    check_owner("mem_solo", 4'b0010, 2'd1);
    req = 4'b1000;
    handoff_step("mem_to_ctl");
    check_owner("mem_to_ctl", 4'b1000, 2'd3);
    req = 4'b1010;
    step();
    step();
    check_owner("ctl_keeps", 4'b1000, 2'd3);
    req = 4'b0010;
    handoff_step("ctl_to_mem");
    check_owner("ctl_to_mem", 4'b0010, 2'd1);

    // Asynchronous reset between edges clears outputs before the next edge.
    #3;
    rst = 1'b0;
    #1;
    check_owner("async_reset", 4'b0000, 2'd0);
    check_eq("async_reset_preempt", 32'(preempt), 32'h0);
    req = 4'b1100;
    step();
    check_owner("held_in_reset", 4'b0000, 2'd0);
    rst = 1'b1;
    step();
    check_owner("post_reset_reg", 4'b0100, 2'd2);

    // ALU then MEM, released hand-off.
    req = 4'b0000;
    pulse_reset();
    req = 4'b0011;
    step();
    check_owner("am_alu", 4'b0001, 2'd0);
    req = 4'b0010;
    handoff_step("am_to_mem");
    check_owner("am_to_mem", 4'b0010, 2'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
